// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision multiplier.
// Holds field widths, the exponent bias, the canonical quiet NaN,
// the 3-bit result class codes and the controller state encoding.
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SIG_W   = 24;   // significand including hidden one
  localparam int PROD_W  = 48;
  localparam int ESUM_W  = 10;   // signed exponent sum width
  localparam int CNT_W   = 5;
  localparam int BIAS    = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'b000,
    CLS_NORMAL = 3'b011,
    CLS_INF    = 3'b100,
    CLS_NAN    = 3'b110
  } fp_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_RND,
    ST_DONE
  } state_t;
endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for a single-precision word.
// Ports: x   - 32-bit IEEE-754 single value
//        cls - class code (denormals are reported as NaN: not supported)
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] x,
  output fp_class_t   cls
);
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = x[30:23];
  assign frac_f = x[22:0];

  always_comb begin
    cls = CLS_NORMAL;
    if (exp_f == '0)
      cls = (frac_f == '0) ? CLS_ZERO : CLS_NAN;
    else if (exp_f == '1)
      cls = (frac_f == '0) ? CLS_INF : CLS_NAN;
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier (shift-add, round-to-nearest-even).
// Ports: clk, rst (async, active high), start (sampled while idle),
//        a, b (operands, captured on the accepted start edge),
//        result/res_class (held until next accepted start),
//        invalid/overflow/underflow (per-operation flags),
//        busy (MUL/NORM/RND in progress), done (one-cycle completion pulse).
module fp_mul_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [2:0]  res_class,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow,
  output logic        busy,
  output logic        done
);
  state_t state, state_next;
  fp_class_t cls_a, cls_b, cls_res;

  logic [PROD_W-1:0]       product, mcand;
  logic [SIG_W-1:0]        mplier, sig;
  logic [CNT_W-1:0]        count;
  logic signed [ESUM_W-1:0] exp_sum;
  logic                    sign, guard, sticky;

  logic [SIG_W-1:0] sig_a, sig_b;
  logic             sign_in, special, spec_inv;
  logic [31:0]      spec_res;

  fp_classify u_cls_a   (.x(a),      .cls(cls_a));
  fp_classify u_cls_b   (.x(b),      .cls(cls_b));
  fp_classify u_cls_res (.x(result), .cls(cls_res));

  assign res_class = cls_res;
  assign sig_a     = {1'b1, a[22:0]};
  assign sig_b     = {1'b1, b[22:0]};
  assign sign_in   = a[31] ^ b[31];
  assign special   = !(cls_a == CLS_NORMAL && cls_b == CLS_NORMAL);

  // Special-case result, resolved in the accepting cycle.
  always_comb begin
    spec_inv = 1'b0;
    spec_res = {sign_in, 31'b0};
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      spec_res = {sign_in, 8'hFF, 23'b0};
    end
  end

  // Normalisation: product lies in [2^46, 2^48).
  logic [SIG_W-1:0]         norm_sig;
  logic                     norm_guard, norm_sticky;
  always_comb begin
    if (product[47]) begin
      norm_sig    = product[47:24];
      norm_guard  = product[23];
      norm_sticky = |product[22:0];
    end else begin
      norm_sig    = product[46:23];
      norm_guard  = product[22];
      norm_sticky = |product[21:0];
    end
  end

  // Round to nearest even; a carry out of the significand leaves 1.000..0,
  // so the fraction becomes zero and the exponent steps up.
  logic                     round_up;
  logic [SIG_W:0]           sig_rnd;
  logic signed [ESUM_W-1:0] exp_rnd;
  logic [FRAC_W-1:0]        frac_rnd;
  assign round_up = guard & (sticky | sig[0]);
  assign sig_rnd  = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
  assign exp_rnd  = sig_rnd[SIG_W] ? exp_sum + 10'sd1 : exp_sum;
  assign frac_rnd = sig_rnd[SIG_W] ? '0 : sig_rnd[FRAC_W-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = special ? ST_DONE : ST_MUL;
      ST_MUL:  if (count == 5'd23) state_next = ST_NORM;
      ST_NORM: state_next = ST_RND;
      ST_RND:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    busy = (state == ST_MUL) || (state == ST_NORM) || (state == ST_RND);
    done = (state == ST_DONE);
  end

  // Datapath. The first of the 24 shift-add iterations is folded into the
  // accepting edge, so MUL itself runs 23 cycles (count 1..23).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      exp_sum   <= '0;
      sign      <= 1'b0;
      sig       <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      result    <= '0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          sign      <= sign_in;
          invalid   <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          if (special) begin
            result  <= spec_res;
            invalid <= spec_inv;
          end else begin
            product <= b[0] ? {{SIG_W{1'b0}}, sig_a} : '0;
            mcand   <= {{(SIG_W-1){1'b0}}, sig_a, 1'b0};
            mplier  <= {1'b0, sig_b[SIG_W-1:1]};
            count   <= 5'd1;
            exp_sum <= $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS));
          end
        end
        ST_MUL: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
        end
        ST_NORM: begin
          sig     <= norm_sig;
          guard   <= norm_guard;
          sticky  <= norm_sticky;
          exp_sum <= product[47] ? exp_sum + 10'sd1 : exp_sum;
        end
        ST_RND: begin
          if (exp_rnd >= 10'sd255) begin
            result   <= {sign, 8'hFF, 23'b0};
            overflow <= 1'b1;
          end else if (exp_rnd <= 10'sd0) begin
            result    <= {sign, 31'b0};
            underflow <= 1'b1;
          end else begin
            result <= {sign, exp_rnd[7:0], frac_rnd};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_in, b_in;
  logic [31:0] result;
  logic [2:0]  res_class;
  logic        invalid, overflow, underflow, busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] obs_res;

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
    .result(result), .res_class(res_class), .invalid(invalid),
    .overflow(overflow), .underflow(underflow), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_class(input logic [31:0] x);
    if (x[30:23] == 8'd0)   return (x[22:0] == 0) ? 3'b000 : 3'b110;
    if (x[30:23] == 8'd255) return (x[22:0] == 0) ? 3'b100 : 3'b110;
    return 3'b011;
  endfunction

  // Reference: exact integer product, then RNE by comparing the discarded
  // remainder against one half of the last kept unit.
  task automatic ref_mul(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic inv,
                         output logic ovf, output logic unf, output logic spec);
    logic [2:0] cx, cy;
    logic s;
    longint unsigned p, q, rem, half;
    int e, sh;
    cx = ref_class(x); cy = ref_class(y);
    s = x[31] ^ y[31];
    inv = 0; ovf = 0; unf = 0; spec = 1;
    if (cx == 3'b110 || cy == 3'b110 || (cx == 3'b100 && cy == 3'b000) ||
        (cx == 3'b000 && cy == 3'b100)) begin
      r = 32'h7FC00000; inv = 1;
    end else if (cx == 3'b100 || cy == 3'b100) begin
      r = {s, 8'hFF, 23'h0};
    end else if (cx == 3'b000 || cy == 3'b000) begin
      r = {s, 31'h0};
    end else begin
      spec = 0;
      p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      q = p >> sh;
      rem = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin r = {s, 8'hFF, 23'h0}; ovf = 1; end
      else if (e <= 0) begin r = {s, 31'h0}; unf = 1; end
      else r = {s, 8'(e), q[22:0]};
    end
  endtask

  // Caller is at a falling edge with the DUT idle; start is raised at once.
  // repulse: cycle in which start is pulsed again with junk operands (-1 none).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int repulse);
    logic [31:0] er;
    logic ei, eo, eu, es;
    int cyc, exp_lat;
    bit seen;
    ref_mul(x, y, er, ei, eo, eu, es);
    exp_lat = es ? 1 : 26;
    a_in = x; b_in = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (done) seen = 1;
      else begin
        if (cyc == 1) check("busy_c1", 32'(busy), es ? 32'd0 : 32'd1);
        start = (cyc == repulse);
        if (start) begin a_in = $urandom; b_in = $urandom; end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", result, er);
    check("class", 32'(res_class), 32'(ref_class(er)));
    check("invalid", 32'(invalid), 32'(ei));
    check("overflow", 32'(overflow), 32'(eo));
    check("underflow", 32'(underflow), 32'(eu));
    obs_res = result;
    $display("op a=%h b=%h -> result=%h class=%b inv=%0b ovf=%0b unf=%0b cycles=%0d",
             x, y, result, res_class, invalid, overflow, underflow, cyc);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("hold", result, er);
  endtask

  function automatic logic [31:0] rnd_normal(input int emin, input int emax);
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(emax, emin));
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_class"}, 32'(res_class), 32'd0);
    check({tag, "_flags"}, 32'({invalid, overflow, underflow}), 32'd0);
  endtask

  logic [31:0] dir_a [7] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F800000,
                             32'h7F000000, 32'h00800000, 32'hFF800000};
  logic [31:0] dir_b [7] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000,
                             32'h7F000000, 32'h00800000, 32'h40000000};
  logic [31:0] dir_r [7] = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h7FC00000,
                             32'h7F800000, 32'h00000000, 32'hFF800000};
  logic [31:0] pool [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                            32'hFF800000, 32'h7FC00001, 32'h00000001};

  initial begin
    int done_cnt;
    logic [31:0] x, y;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases, back to back; first start on the first edge after reset.
    for (int i = 0; i < 7; i++) begin
      run_op(dir_a[i], dir_b[i], -1);
      check("directed", obs_res, dir_r[i]);
    end

    // Start re-pulsed mid-operation must be ignored.
    run_op(32'h3FC00000, 32'h40000000, 10);
    check("repulse", obs_res, 32'h40400000);

    // Reset in cycle 12 aborts the operation.
    a_in = 32'h40A00000; b_in = 32'h40400000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check_reset_outputs("abort_idle");
    run_op(32'h40A00000, 32'h40400000, -1);
    check("after_abort", obs_res, 32'h41700000);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3, 0))
        0: begin x = rnd_normal(100, 154); y = rnd_normal(100, 154); end
        1: begin x = rnd_normal(1, 254);   y = rnd_normal(1, 254);   end
        2: begin x = $urandom;             y = $urandom;             end
        default: begin
          x = pool[$urandom_range(5, 0)];
          y = ($urandom_range(1, 0) == 1) ? pool[$urandom_range(5, 0)] : rnd_normal(1, 254);
          x[31] = 1'($urandom_range(1, 0));
        end
      endcase
      run_op(x, y, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request; sampled only when busy=0.
REQ-004 a, b  input  32 each  IEEE-754 single operands; latched on the accepted start edge.
REQ-005 result  output  32  product; held stable from done until the next accepted start.
REQ-006 res_class  output  3  class of result: ZERO=000, INF=100, NAN=110, NORMAL=011.
REQ-007 invalid, overflow, underflow  output  1 each  sticky per operation; cleared on accepted start.
REQ-008 busy  output  1  high from the edge after an accepted start until DONE is entered.
REQ-009 done  output  1  one-cycle pulse; result and flags valid in that cycle.

Function
REQ-010 Operand class: exp=0,frac=0 ZERO; exp=0,frac!=0 NAN (no denormal support); exp=255,frac=0 INF; exp=255,frac!=0 NAN; else NORMAL.
REQ-011 FSM states IDLE, MUL, NORM, RND, DONE; DONE returns to IDLE after one cycle.
REQ-012 IDLE + start: latch operands, compute classes, set sign = a[31] xor b[31]; special case -> DONE, both NORMAL -> MUL.
REQ-013 Special: any NAN, or INF x ZERO -> 0x7FC00000, invalid=1; INF x non-NaN non-zero -> {sign,0xFF,0}; ZERO x NORMAL/ZERO -> {sign,31'b0}.
REQ-014 MUL: 24-iteration shift-add of the 24-bit significands (hidden 1) into a 48-bit product, one iteration per cycle, 5-bit iteration counter.
REQ-015 Exponent: 10-bit signed sum ea + eb - 127, computed on entry to MUL.
REQ-016 NORM: if product[47]=1, shift right one and exponent +1; keep 24-bit significand, guard bit, sticky = OR of remaining bits.
REQ-017 RND: round-to-nearest-even; rounding carry out of the significand increments exponent and renormalises.
REQ-018 After RND: exponent >= 255 -> {sign,0xFF,0}, overflow=1; exponent <= 0 -> {sign,31'b0}, underflow=1; else packed normal.
REQ-019 Latency: special case done in cycle 1 after the start edge; normal case done in cycle 26 (24 MUL + NORM + RND).
REQ-020 start while busy=1 or in DONE is ignored; in-flight operation unaffected.
REQ-021 start asserted on the cycle done returns to IDLE is accepted normally; back-to-back throughput is one operation per 27 cycles (normal).
REQ-022 res_class reflects the final packed result under REQ-010 rules.

Reset
REQ-023 rst forces IDLE immediately, aborts any operation; result=0, res_class=000, invalid=overflow=underflow=0, busy=0, done=0, counter=0.
REQ-024 The first start is accepted on the first rising edge with rst low.

Structure
REQ-025 Shared package fp_pkg holds class codes, state encoding, BIAS=127, QNAN=32'h7FC00000, field widths.
REQ-026 A purely combinational sub-module fp_classify (32-bit in, 3-bit class) is instantiated twice for operands and once for the result.
REQ-027 Datapath registers (product, multiplicand, counter, exponent) are reset asynchronously with the FSM.

Verification
REQ-028 a=0x3FC00000, b=0x40000000 -> result 0x40400000, res_class 011, done in cycle 26, flags 0.
REQ-029 a=0xC0000000, b=0x40400000 -> 0xC0C00000; a=0x3F800001, b=0x3F800001 -> 0x3F800002 (RNE).
REQ-030 a=0x7F800000, b=0x00000000 -> 0x7FC00000, invalid=1, res_class 110, done in cycle 1.
REQ-031 a=b=0x7F000000 -> 0x7F800000, overflow=1; a=b=0x00800000 -> 0x00000000, underflow=1.
REQ-032 start re-pulsed with new operands in cycle 10 of a normal op -> ignored, original result returned at cycle 26.
REQ-033 rst pulsed in cycle 12 of a normal op -> busy=0, done never pulses, outputs at reset values; next start completes correctly.
